// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Computes ans = op1 - op2 one bit per
// clock, LSB first, as op1 + ~op2 + 1 through a single full-adder slice and a
// carry flip-flop. The carry flip-flop is preset to 1 on acceptance, which
// supplies the "+1" of the two's-complement negation.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset; aborts any operation in flight
//   start    in   request a subtraction; accepted in IDLE or DONE
//   op1      in   minuend, sampled only on the accepting edge
//   op2      in   subtrahend, sampled only on the accepting edge
//   ans      out  op1 - op2 mod 2^WIDTH (registered, held until next result)
//   borrow   out  1 when op1 < op2 unsigned (inverse of the final carry)
//   overflow out  signed overflow (carry into MSB xor carry out of MSB)
//   zero     out  1 when ans == 0
//   busy     out  operation in progress (high while bits are being processed)
//   done     out  one-cycle pulse; ans and flags are valid from this cycle on
//
// Timing: start accepted at edge k, bits processed at edges k+1 .. k+WIDTH,
// done high during the cycle following edge k+WIDTH.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] ans,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  // Counter just wide enough to index WIDTH bits; it reaches WIDTH-1 on the
  // last bit and never needs to represent WIDTH itself.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Full-adder carry: majority of the three inputs.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    maj3 = (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder sum bit.
  function automatic logic sum3(input logic x, input logic y, input logic z);
    sum3 = x ^ y ^ z;
  endfunction

  state_t            state_r;
  state_t            state_next_s;

  logic [WIDTH-1:0]  a_r;        // minuend shift register
  logic [WIDTH-1:0]  b_r;        // inverted subtrahend shift register
  logic [WIDTH-1:0]  res_r;      // result assembles from the MSB end
  logic              carry_r;
  logic              cin_msb_r;  // carry into the MSB slice
  logic [CW-1:0]     count_r;

  logic [WIDTH-1:0]  ans_r;
  logic              borrow_r;
  logic              overflow_r;
  logic              zero_r;
  logic              busy_r;
  logic              done_r;

  logic              accept_s;
  logic              shifting_s;
  logic              last_bit_s;
  logic              pre_msb_s;
  logic              sum_s;
  logic              carry_next_s;
  logic [WIDTH-1:0]  res_next_s;

  // Full-adder slice and control decodes for the current bit.
  always_comb begin
    sum_s        = 1'b0;
    carry_next_s = 1'b0;
    res_next_s   = res_r;
    shifting_s   = 1'b0;
    accept_s     = 1'b0;
    last_bit_s   = 1'b0;
    pre_msb_s    = 1'b0;

    sum_s        = sum3(a_r[0], b_r[0], carry_r);
    carry_next_s = maj3(a_r[0], b_r[0], carry_r);
    res_next_s   = {sum_s, res_r[WIDTH-1:1]};

    if (state_r == ST_SHIFT) begin
      shifting_s = 1'b1;
    end else begin
      shifting_s = 1'b0;
    end

    // A request is taken in IDLE and also in DONE for back-to-back use.
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end

    if (count_r == CW'(WIDTH - 1)) begin
      last_bit_s = 1'b1;
    end else begin
      last_bit_s = 1'b0;
    end

    // The bit at position WIDTH-2 produces the carry into the MSB slice.
    if (count_r == CW'(WIDTH - 2)) begin
      pre_msb_s = 1'b1;
    end else begin
      pre_msb_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Operand shift registers, carry chain and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      res_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      cin_msb_r <= 1'b0;
      count_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r       <= op1;
      b_r       <= ~op2;
      res_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b1;
      cin_msb_r <= 1'b0;
      count_r   <= {CW{1'b0}};
    end else if (shifting_s) begin
      a_r     <= {1'b0, a_r[WIDTH-1:1]};
      b_r     <= {1'b0, b_r[WIDTH-1:1]};
      res_r   <= res_next_s;
      carry_r <= carry_next_s;
      count_r <= count_r + CW'(1);
      if (pre_msb_s) begin
        cin_msb_r <= carry_next_s;
      end else begin
        cin_msb_r <= cin_msb_r;
      end
    end else begin
      a_r       <= a_r;
      b_r       <= b_r;
      res_r     <= res_r;
      carry_r   <= carry_r;
      cin_msb_r <= cin_msb_r;
      count_r   <= count_r;
    end
  end

  // Result and flags latch on the edge that processes the final bit and are
  // otherwise held, so they stay stable while the next operation runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ans_r      <= {WIDTH{1'b0}};
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else if (shifting_s && last_bit_s) begin
      ans_r      <= res_next_s;
      borrow_r   <= ~carry_next_s;
      overflow_r <= cin_msb_r ^ carry_next_s;
      zero_r     <= (res_next_s == {WIDTH{1'b0}});
    end else begin
      ans_r      <= ans_r;
      borrow_r   <= borrow_r;
      overflow_r <= overflow_r;
      zero_r     <= zero_r;
    end
  end

  // Handshake outputs, registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_SHIFT);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  assign ans      = ans_r;
  assign borrow   = borrow_r;
  assign overflow = overflow_r;
  assign zero     = zero_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected values come
// from an arithmetic reference model (plain integer subtraction and signed
// range checks) and from hand-computed constant vectors.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] ans;
  logic         borrow;
  logic         overflow;
  logic         zero;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op1      (op1),
    .op2      (op2),
    .ans      (ans),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference: plain modular subtraction, unsigned compare, signed range test.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic bo,
                                output logic ov, output logic z);
    int sa;
    int sb;
    int sd;
    d  = a - b;
    bo = (a < b);
    sa = a[W-1] ? (int'(a) - (1 << W)) : int'(a);
    sb = b[W-1] ? (int'(b) - (1 << W)) : int'(b);
    sd = sa - sb;
    ov = (sd > ((1 << (W-1)) - 1)) || (sd < -(1 << (W-1)));
    z  = (d == '0);
  endfunction

  // Present operands with start for one accepting edge (called on a negedge).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    op1   = a;
    op2   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges until done, starting from 1 (the accepting edge); bounded.
  task automatic wait_done(inout int cyc, output bit timed_out);
    while (done !== 1'b1 && cyc < 4*W) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    op1     = '0;
    op2     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ans, borrow, overflow, zero, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ans=%h b=%b o=%b z=%b busy=%b done=%b, want all 0",
               ans, borrow, overflow, zero, busy, done);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [W-1:0] va [5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h5A};
    logic [W-1:0] vb [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h5A};
    logic [W-1:0] ea [5] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00};
    logic [2:0]   ef [5] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001};
    for (int i = 0; i < 5; i++) begin
      int cyc;
      bit to;
      launch(va[i], vb[i]);
      cyc = 1;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL directed_busy[%0d]: got %b want 1", i, busy);
      end
      wait_done(cyc, to);
      checks++;
      if (to || cyc != W + 1) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges timeout=%0d want %0d", i, cyc, to, W + 1);
      end
      checks++;
      if (ans !== ea[i]) begin
        errors++;
        $display("FAIL directed_ans[%0d]: got %h want %h", i, ans, ea[i]);
      end
      checks++;
      if ({borrow, overflow, zero} !== ef[i]) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got bo/ov/z=%b want %b", i, {borrow, overflow, zero}, ef[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_pulse[%0d]: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] ed;
      logic ebo, eov, ez;
      int cyc;
      bit to;
      a = W'($urandom_range(0, 255));
      b = (i % 8 == 0) ? a : W'($urandom_range(0, 255));
      model(a, b, ed, ebo, eov, ez);
      launch(a, b);
      // Scramble operands after acceptance; they must have no effect.
      op1 = W'($urandom);
      op2 = W'($urandom);
      cyc = 1;
      wait_done(cyc, to);
      checks++;
      if (to || cyc != W + 1) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d edges timeout=%0d want %0d", i, cyc, to, W + 1);
      end
      checks++;
      if ({ans, borrow, overflow, zero} !== {ed, ebo, eov, ez}) begin
        errors++;
        $display("FAIL random_result[%0d] %h-%h: got ans=%h bo=%b ov=%b z=%b want ans=%h bo=%b ov=%b z=%b",
                 i, a, b, ans, borrow, overflow, zero, ed, ebo, eov, ez);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to;
    // start held high from the first request through the DONE cycle.
    op1   = 8'h5A;
    op2   = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    wait_done(cyc, to);
    checks++;
    if (to || ans !== 8'h00 || zero !== 1'b1 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got ans=%h z=%b bo=%b timeout=%0d want ans=00 z=1 bo=0", ans, zero, borrow, to);
    end
    op1 = 8'h10;
    op2 = 8'h01;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b done=%b want 1 0", busy, done);
    end
    checks++;
    if (ans !== 8'h00) begin
      errors++;
      $display("FAIL b2b_hold: got ans=%h want 00 during shift", ans);
    end
    wait_done(cyc, to);
    checks++;
    if (to || cyc != W + 1 || ans !== 8'h0F || zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got ans=%h z=%b edges=%0d timeout=%0d want ans=0f z=0 edges=%0d",
               ans, zero, cyc, to, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int cyc;
    int pulses;
    launch(8'h20, 8'h10);
    cyc    = 1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    op1   = 8'hFF;
    op2   = 8'h00;
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    for (int i = 0; i < 4*W; i++) begin
      if (done === 1'b1) begin
        pulses++;
        checks++;
        if (cyc != W + 1 || ans !== 8'h10 || borrow !== 1'b0) begin
          errors++;
          $display("FAIL ignore_result: got ans=%h bo=%b edges=%0d want ans=10 bo=0 edges=%0d",
                   ans, borrow, cyc, W + 1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d done pulses want 1", pulses);
    end
  endtask

  task automatic test_reset_abort;
    int pulses;
    int cyc;
    bit to;
    launch(8'h33, 8'h11);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ans, borrow, overflow, zero, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_async: got ans=%h bo=%b ov=%b z=%b busy=%b done=%b want all 0",
               ans, borrow, overflow, zero, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 2*W; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d cycles with done/busy want 0", pulses);
    end
    launch(8'h09, 8'h04);
    cyc = 1;
    wait_done(cyc, to);
    checks++;
    if (to || ans !== 8'h05 || {borrow, overflow, zero} !== 3'b000) begin
      errors++;
      $display("FAIL abort_next_op: got ans=%h bo/ov/z=%b timeout=%0d want ans=05 000",
               ans, {borrow, overflow, zero}, to);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_ignore_start;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; computes ans = op1 - op2 one bit per clock, LSB first.
- Implemented as op1 + ~op2 + 1 through a single full-adder slice and a carry flip-flop.
- Complements the combinational ripple adder in the ALU datapath. Used where area matters more than latency, such as the multi-cycle ALU path and compare/branch-offset checks.
- Start/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a subtraction; sampled on rising clk.
- op1  input  WIDTH  minuend; sampled only on the edge that accepts start.
- op2  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
- ans  output  WIDTH  difference op1 - op2 (mod 2^WIDTH); registered.
- borrow  output  1  1 when op1 < op2 unsigned (inverse of final carry).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  1 when ans == 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; ans and flags are valid from this cycle on.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - state = IDLE.
  - ans, borrow, overflow, zero, busy, done = 0.
  - shift registers, carry flip-flop and bit counter = 0.
  - Reset asserted mid-operation aborts the operation. No done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at an edge: load A <= op1, B <= ~op2, carry <= 1, count <= 0, go to SHIFT.
  - busy = 1 from the following cycle.
- SHIFT (busy = 1), each edge:
  - s = A[0] ^ B[0] ^ carry.
  - carry <= majority(A[0], B[0], carry).
  - A and B shift right by 1; s enters the result register at its MSB (result shifts right).
  - When count == WIDTH-2, latch cin_msb <= next carry (the carry into the MSB).
  - count increments.
  - After the edge processing bit WIDTH-1, go to DONE and latch the outputs on that same edge:
    - ans <= assembled result.
    - borrow <= ~cout.
    - overflow <= cin_msb ^ cout.
    - zero <= (assembled result == 0).
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - Next edge goes to IDLE.
  - If start = 1 during the DONE cycle, the request is accepted exactly as in IDLE and the state goes straight to SHIFT (back-to-back operation).
- Latency:
  - start accepted at edge k.
  - Bits are processed at edges k+1 .. k+WIDTH.
  - done is high during the cycle after edge k+WIDTH.
  - Total WIDTH+1 cycles from start to done; throughput one result per WIDTH+1 cycles.
- Output hold: ans and flags hold their values until the latching edge of the next operation. They do not change during SHIFT.
- start while in SHIFT: ignored; operands are not resampled.
- op1/op2 changes after acceptance: no effect.
- Width rules: all arithmetic is mod 2^WIDTH; count is ceil(log2(WIDTH)) bits wide and must not wrap before WIDTH bits are processed.

Test Plan:
- op1 = 0x05, op2 = 0x03, start pulse -> done exactly 9 cycles after the accepting edge; ans = 0x02, borrow = 0, overflow = 0, zero = 0.
- op1 = 0x03, op2 = 0x05 -> ans = 0xFE, borrow = 1, overflow = 0, zero = 0.
- Signed overflow cases:
  - op1 = 0x80, op2 = 0x01 -> ans = 0x7F, overflow = 1, borrow = 0.
  - op1 = 0x7F, op2 = 0xFF -> ans = 0x80, overflow = 1, borrow = 1.
- op1 = 0x5A, op2 = 0x5A -> ans = 0x00, zero = 1, borrow = 0. Then start held high through the DONE cycle with op1 = 0x10, op2 = 0x01 -> second done 9 cycles later, ans = 0x0F.
- start = 1 with op1 = 0x20, op2 = 0x10; pulse start again 3 cycles later with op1 = 0xFF, op2 = 0x00 -> second request ignored; ans = 0x10, single done pulse.
- Start an operation, drive reset_n low 4 cycles in, then release -> all outputs 0 immediately (asynchronously); no done pulse; the next start of 0x09 - 0x04 gives ans = 0x05.
